// File: rtl/shift_reg_piso.sv
// rtl/shift_reg_piso.sv - parallel-in serial-out shift register with valid/ready on both sides
// A word is captured on a load handshake and streamed one bit per accepted output transfer.
module shift_reg_piso #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   input  logic             sout_ready,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sreg_shifted;
   logic             last;
   logic             load_hs;
   logic             xfer;

   assign last       = (cnt_q == '0);
   assign sout_valid = (state_q == SHIFT);
   assign sout       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
   assign xfer       = sout_valid & sout_ready;
   assign done       = xfer & last;
   // Ready during the final transfer lets the next word follow with no idle cycle.
   assign load_ready = reset & ((state_q == IDLE) | ((state_q == SHIFT) & last & sout_ready));
   assign load_hs    = load_valid & load_ready;

   always_comb begin
      sreg_shifted = '0;
      if (MSB_FIRST) begin
         sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
         sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (load_hs) begin
               sreg_d  = din;
               cnt_d   = CW'(WIDTH - 1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (xfer) begin
               if (!last) begin
                  sreg_d = sreg_shifted;
                  cnt_d  = cnt_q - 1'b1;
               end else if (load_hs) begin
                  sreg_d = din;
                  cnt_d  = CW'(WIDTH - 1);
               end else begin
                  // Clearing keeps sout at 0 while idle.
                  sreg_d  = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_shift_reg_piso.sv
// tb/tb_shift_reg_piso.sv - directed bench for shift_reg_piso, MSB-first and LSB-first instances
// Both instances share stimulus; expected bits come from the word under test.
module tb_shift_reg_piso;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic       load_valid;
   logic       sout_ready;

   logic m_load_ready, m_sout, m_sout_valid, m_done;
   logic l_load_ready, l_sout, l_sout_valid, l_done;

   int n_cmp = 0;
   int n_err = 0;

   shift_reg_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (m_load_ready),
      .sout       (m_sout),
      .sout_valid (m_sout_valid),
      .sout_ready (sout_ready),
      .done       (m_done)
   );

   shift_reg_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (l_load_ready),
      .sout       (l_sout),
      .sout_valid (l_sout_valid),
      .sout_ready (sout_ready),
      .done       (l_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_both(input string tag, input logic lr, input logic sv, input logic dn);
      check({tag, ".m_load_ready"}, m_load_ready, lr);
      check({tag, ".m_sout_valid"}, m_sout_valid, sv);
      check({tag, ".m_done"}, m_done, dn);
      check({tag, ".l_load_ready"}, l_load_ready, lr);
      check({tag, ".l_sout_valid"}, l_sout_valid, sv);
      check({tag, ".l_done"}, l_done, dn);
   endtask

   // Called at posedge+1 in IDLE; returns at posedge+1 with the first bit presented.
   task automatic load_word(input logic [7:0] w);
      din        = w;
      load_valid = 1'b1;
      @(negedge clk);
      check_both("load", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
   endtask

   // Streams a loaded word; optionally stalls before bit stall_at and chains next_w.
   task automatic stream(input string tag, input logic [7:0] w, input int stall_at, input int stall_n,
                         input logic chain, input logic [7:0] next_w);
      if (chain) begin
         din        = next_w;
         load_valid = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               sout_ready = 1'b0;
               @(negedge clk);
               check({tag, ".stall.m_sout"}, m_sout, w[7-i]);
               check({tag, ".stall.l_sout"}, l_sout, w[i]);
               check_both({tag, ".stall"}, 1'b0, 1'b1, 1'b0);
               @(posedge clk);
               #1;
            end
         end
         sout_ready = 1'b1;
         @(negedge clk);
         check({tag, ".m_sout"}, m_sout, w[7-i]);
         check({tag, ".l_sout"}, l_sout, w[i]);
         check_both(tag, (i == 7), 1'b1, (i == 7));
         @(posedge clk);
         #1;
      end
      if (chain) load_valid = 1'b0;
      if (!chain) begin
         @(negedge clk);
         check_both({tag, ".idle"}, 1'b1, 1'b0, 1'b0);
         check({tag, ".idle.m_sout"}, m_sout, 1'b0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset      = 1'b1;
      din        = 8'h00;
      load_valid = 1'b0;
      sout_ready = 1'b1;

      #2;
      reset = 1'b0;
      #1;
      check_both("reset", 1'b0, 1'b0, 1'b0);
      check("reset.m_sout", m_sout, 1'b0);
      check("reset.l_sout", l_sout, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_both("release", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      load_word(8'hA5);
      stream("a5", 8'hA5, -1, 0, 1'b0, 8'h00);

      load_word(8'h01);
      stream("01", 8'h01, -1, 0, 1'b0, 8'h00);

      load_word(8'hF0);
      stream("f0", 8'hF0, -1, 0, 1'b1, 8'h0F);
      stream("0f", 8'h0F, -1, 0, 1'b0, 8'h00);

      load_word(8'hC3);
      stream("c3", 8'hC3, 2, 3, 1'b0, 8'h00);

      load_word(8'hFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("ff.m_sout", m_sout, 1'b1);
         check("ff.l_sout", l_sout, 1'b1);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      check_both("abort", 1'b0, 1'b0, 1'b0);
      check("abort.m_sout", m_sout, 1'b0);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_both("abort.release", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      load_word(8'h00);
      stream("00", 8'h00, -1, 0, 1'b0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_reg_piso.md
# shift_reg_piso

Parallel-in serial-out shift register that consumes a WIDTH-bit word captured by the team's reset-able D-latch bank and streams it out one bit per clock. It sits directly downstream of the latch stage: the latch bank's true outputs feed `din`, and this block serialises them toward a serial link or bit-level consumer. Valid/ready handshakes on both sides allow back-to-back words with no bubble and arbitrary output stalls.

## Interface
- `WIDTH`, default 8, word length in bits; legal range 2..32.
- `MSB_FIRST`, default 1. When 1, `din[WIDTH-1]` is shifted out first; when 0, `din[0]` is shifted out first.

- `clk`  input  1  sole clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `din`  input  WIDTH  parallel word from the latch bank.
- `load_valid`  input  1  `din` holds a word to be serialised.
- `load_ready`  output  1  block accepts `din` this cycle.
- `sout`  output  1  current serial bit.
- `sout_valid`  output  1  `sout` carries a data bit.
- `sout_ready`  input  1  consumer takes `sout` this cycle.
- `done`  output  1  last bit of the word is transferred this cycle.

## Operation
- **Reset values.** While `reset` is 0, asynchronously: state=IDLE, shift register=0, bit counter=0, `sout`=0, `sout_valid`=0, `load_ready`=0, `done`=0.
- **Counter.** `cnt` is $clog2(WIDTH) bits wide and counts the bits remaining after the current one. `last` = (`cnt` == 0).
- **State IDLE.**
  - `sout_valid`=0 and `load_ready`=1.
  - A load handshake (`load_valid` & `load_ready`) captures `din`, sets `cnt`=WIDTH-1 and moves to SHIFT.
- **State SHIFT.**
  - `sout_valid`=1.
  - `sout` is the register MSB when MSB_FIRST=1, otherwise the register LSB.
  - An output transfer (`sout_valid` & `sout_ready`) with !`last` shifts the register by one (toward MSB when MSB_FIRST, else toward LSB) and decrements `cnt`.
- **No transfer.** If `sout_ready`=0, the register, `cnt` and `sout` hold unchanged (stall). A stall of any length is legal.
- **Final transfer.** An output transfer with `last`=1 is the final bit:
  - `done`=1 combinationally in that cycle.
  - If a load handshake also occurs, the new word is captured, `cnt`=WIDTH-1 and the state stays SHIFT (no bubble).
  - Otherwise the block returns to IDLE.
- **`load_ready` logic.** `load_ready` = (state==IDLE) | (state==SHIFT & `last` & `sout_ready`), gated to 0 while `reset`=0. It is combinational from `sout_ready`.
- **`done` logic.** `done` = `sout_valid` & `sout_ready` & `last`. It is never asserted in IDLE.
- **Input don't-cares.** `din` is ignored without a load handshake. `load_valid` asserted while `load_ready`=0 has no effect; the upstream holds `din` until accepted.
- **Reset mid-word.** A reset in the middle of a word aborts it. After release the block is in IDLE and the aborted word is never resumed.

## Timing
- **Latency.** A load accepted at edge N presents its first bit from N (just after the edge) with `sout_valid`=1.
- **Unstalled word.** With `sout_ready` held at 1, bits occupy cycles N+1..N+WIDTH. `done` is high in cycle N+WIDTH, the cycle ending with the edge that transfers the last bit.
- **Throughput.** One bit per cycle when `sout_ready`=1. Back-to-back words give a continuous stream, WIDTH cycles per word, with no idle cycle.
- **Reset release.** `load_ready` rises combinationally once `reset` goes to 1 and state is IDLE. The first load can be accepted at the first rising edge after release.
- **Output paths.** All outputs except `load_ready` and `done` are registered or decoded from state only. `load_ready` and `done` depend combinationally on `sout_ready`; the consumer must not create a loop through them.

## Test plan
- **Reset values.** Assert `reset`=0 asynchronously mid-cycle -> all outputs 0 immediately. Release -> `load_ready`=1, `sout_valid`=0.
- **Single word, MSB first.** WIDTH=8, MSB_FIRST=1, load 8'hA5, `sout_ready`=1 -> `sout` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles. `done` high only on the 8th. IDLE on the 9th.
- **Single word, LSB first.** MSB_FIRST=0, load 8'hA5 -> `sout` = 1,0,1,0,0,1,0,1 (LSB first; A5 is palindromic). Repeat with 8'h01 -> 1,0,0,0,0,0,0,0.
- **Back-to-back words.** Load 8'hF0, then 8'h0F presented with `load_valid`=1 throughout -> second load accepted in the `done` cycle. 16-bit continuous stream 11110000 00001111, `sout_valid` never drops.
- **Stall.** Drop `sout_ready` for 3 cycles after bit 2 of 8'hC3 -> `sout` holds bit 2 for 4 cycles, `load_ready`=0 during the stall, full sequence 11000011 still delivered, `done` once.
- **Abort.** Pulse `reset`=0 after 4 bits of 8'hFF -> `sout_valid`=0 at once. After release, load 8'h00 -> eight 0 bits; no residual 1s.
